// File: rtl/grf_writeback_sink_if.sv
// Bundle of the register-file write port, read ports and writeback trace stream.
// master: the core / consumer side (drives write and read addresses, takes trace).
// slave:  the register file (returns read data, sources the trace stream).
interface grf_writeback_sink_if #(
    parameter int unsigned CNT_W = 3
);
    logic             we;
    logic [4:0]       wa;
    logic [31:0]      wd;
    logic [31:0]      pc;
    logic [4:0]       ra1;
    logic [4:0]       ra2;
    logic [31:0]      rd1;
    logic [31:0]      rd2;
    logic             trace_valid;
    logic             trace_ready;
    logic [31:0]      trace_pc;
    logic [4:0]       trace_addr;
    logic [31:0]      trace_data;
    logic [CNT_W-1:0] trace_count;
    logic             trace_overflow;

    modport master (
        output we, wa, wd, pc, ra1, ra2, trace_ready,
        input  rd1, rd2, trace_valid, trace_pc, trace_addr, trace_data,
               trace_count, trace_overflow
    );

    modport slave (
        input  we, wa, wd, pc, ra1, ra2, trace_ready,
        output rd1, rd2, trace_valid, trace_pc, trace_addr, trace_data,
               trace_count, trace_overflow
    );
endinterface

// File: rtl/grf_writeback_sink.sv
// General register file (32 x 32, $0 hardwired to zero) fed by the writeback
// selectors, with two combinational read ports that bypass a same-cycle write,
// and a small circular FIFO recording every writeback as (pc, reg, data).
// Ports: clk, reset (synchronous, active-low), bus (slave modport: write port
// we/wa/wd/pc, read ports ra1/ra2 -> rd1/rd2, trace valid/ready stream with
// occupancy count and sticky overflow flag).
module grf_writeback_sink #(
    parameter int unsigned TRACE_DEPTH = 4,
    parameter int unsigned CNT_W       = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    grf_writeback_sink_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(TRACE_DEPTH);
    localparam int unsigned NREG  = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
    } trace_rec_t;

    logic [31:0]      regs [NREG];
    trace_rec_t       fifo [TRACE_DEPTH];
    trace_rec_t       head;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             empty;
    logic             full;
    logic             pop;
    logic             push_ok;

    // Register array; $0 is never written so it stays at its reset value
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.we && bus.wa != 5'd0) begin
            regs[bus.wa] <= bus.wd;
        end
    end

    // Read ports: $0 first, then same-cycle write bypass, then stored value
    always_comb begin
        bus.rd1 = '0;
        if (bus.ra1 != 5'd0) begin
            bus.rd1 = (bus.we && bus.wa == bus.ra1) ? bus.wd : regs[bus.ra1];
        end
    end

    always_comb begin
        bus.rd2 = '0;
        if (bus.ra2 != 5'd0) begin
            bus.rd2 = (bus.we && bus.wa == bus.ra2) ? bus.wd : regs[bus.ra2];
        end
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(TRACE_DEPTH));
    assign pop     = !empty && bus.trace_ready;
    assign push_ok = bus.we && (!full || pop);

    // Trace storage; contents are don't-care while empty, so no reset
    always_ff @(posedge clk) begin
        if (reset && push_ok) begin
            fifo[wr_ptr] <= {bus.pc, bus.wa, bus.wd};
        end
    end

    // Pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (push_ok && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push_ok) begin
                count <= count - CNT_W'(1);
            end
            if (bus.we && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    // Head entry, zeroed while empty
    always_comb begin
        head = fifo[rd_ptr];
        if (empty) begin
            head = '0;
        end
    end

    assign bus.trace_valid    = !empty;
    assign bus.trace_pc       = head.pc;
    assign bus.trace_addr     = head.addr;
    assign bus.trace_data     = head.data;
    assign bus.trace_count    = count;
    assign bus.trace_overflow = overflow;
endmodule

// File: doc/grf_writeback_sink.md
Name: grf_writeback_sink

Overview:
- General register file that consumes the writeback selector outputs: write address (rt/rd/$31) and write data (ALU/DM/lui/PC+4) on the write port.
- Provides two combinational read ports with same-cycle write bypass.
- Provides a buffered writeback trace stream of (pc, reg, data) records with a valid/ready handshake, for testbench logging and the later pipelined core.

Parameters:
- TRACE_DEPTH, 4, trace FIFO entries; power of two, at least 2.
- CNT_W, 3, width of trace_count; equals clog2(TRACE_DEPTH+1).

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-low; low at a rising edge resets
- we  input  1  register write enable
- wa  input  5  write address from write-address select
- wd  input  32  write data from write-data select
- pc  input  32  PC of the instruction writing back; trace only
- ra1  input  5  read address 1 (rs)
- ra2  input  5  read address 2 (rt)
- rd1  output  32  read data 1, combinational
- rd2  output  32  read data 2, combinational
- trace_valid  output  1  head trace entry is valid
- trace_ready  input  1  consumer accepts head entry
- trace_pc  output  32  head entry PC
- trace_addr  output  5  head entry register number
- trace_data  output  32  head entry data
- trace_count  output  CNT_W  entries currently buffered
- trace_overflow  output  1  sticky: a trace record was dropped

Behaviour:
- Register array: 32 x 32 bits.
  - Reset (reset==0 at posedge) clears all registers to 0.
  - Write at posedge when reset==1, we==1 and wa!=0: reg[wa] <= wd.
  - $0 is never written and always reads 0.
- Read ports (purely combinational):
  - rdN = 0 if raN==0.
  - Otherwise rdN = wd if we==1 and wa==raN (bypass).
  - Otherwise rdN = reg[raN].
  - ra1==ra2 returns identical data on both ports.
- Trace push: every cycle with we==1 pushes {pc, wa, wd}, including wa==0. A $0 record carries wd unchanged.
- Trace pop: when trace_valid==1 and trace_ready==1 at a posedge.
- FIFO organisation: circular buffer, read/write pointers of clog2(TRACE_DEPTH) bits, wrapping modulo TRACE_DEPTH.
  - trace_count tracks occupancy from 0 to TRACE_DEPTH.
  - trace_valid = (trace_count != 0).
  - Head outputs come from registered storage at the read pointer and are forced to 0 when empty.
  - First-word latency: a push at edge N gives trace_valid==1 after edge N.
- Boundary cases:
  - Empty and pushing, no pop possible: count becomes 1.
  - Push and pop in the same cycle, not full: both occur, count unchanged.
  - Full, push and pop together: both occur, count stays TRACE_DEPTH, no overflow.
  - Full, push without pop: record dropped, stored entries unchanged, trace_overflow <= 1.
  - trace_ready high while empty: no effect.
- trace_overflow stays 1 until reset.
- Reset mid-operation clears registers, pointers, trace_count and trace_overflow in the same edge. Any we/trace_ready presented in that cycle is ignored.
- Reset values:
  - rd1/rd2 follow the cleared array (0 unless bypassed).
  - trace_valid, trace_pc, trace_addr, trace_data, trace_count, trace_overflow are all 0.

Test Plan:
- Reset low for 1 edge, then read all 32 addresses -> every rd1/rd2 == 0, trace_count==0, trace_valid==0.
- we=1, wa=8, wd=0x1234_5678, pc=0x3000, ra1=8 in the same cycle:
  - before the edge, rd1==0x1234_5678 (bypass);
  - after the edge, rd1 still 0x1234_5678 with we=0;
  - trace head == {0x3000, 8, 0x1234_5678}.
- we=1, wa=0, wd=0xFFFF_FFFF -> rd1 with ra1=0 stays 0 before and after the edge; trace records addr 0 with data 0xFFFF_FFFF.
- trace_ready=0, five writes (pc 0x3000..0x3010), TRACE_DEPTH=4:
  - trace_count==4 and trace_overflow==1;
  - draining yields pcs 0x3000, 0x3004, 0x3008, 0x300C in order;
  - after drain trace_valid==0 and trace_overflow is still 1.
- With 4 entries buffered, assert we=1 and trace_ready=1 together -> count stays 4, overflow stays 0, the new entry appears last after wrap-around.
- With 2 entries buffered and reg 5 written, pull reset low for one edge -> reg 5 reads 0, trace_count==0, trace_overflow==0; the same-cycle we=1 write is not stored.
